// File: rtl/alarm_controller.sv
// ---------------------------------------------------------------------------
// alarm_controller
// HH:MM alarm for the digital clock, running in the 400 Hz tick domain.
// Holds and edits the alarm time with the push buttons, compares it against
// the running time, and sequences ring / snooze / stop.
//
// Ports
//   i_clk, i_rst_n          400 Hz clock, asynchronous active-low reset
//   i_tick_1hz              one-cycle pulse per second
//   i_btn_u/d/l/m/r         one-cycle button pulses (up/down/left/mid/right)
//   i_alarm_mode            switch level: request alarm edit
//   i_arm                   switch level: alarm enabled
//   i_hour_t..i_sec_o       current time, BCD digits
//   o_al_hour_t..o_al_min_o stored alarm, BCD digits
//   o_config_digit          edit blink mask, bit7..bit4 = cursor 0..3
//   o_show_alarm            display mux select (1 = alarm digits)
//   o_ringing               buzzer/flash enable
//   o_snoozing              snooze active
// ---------------------------------------------------------------------------
module alarm_controller #(
   parameter int unsigned RING_SEC   = 60,
   parameter int unsigned SNOOZE_SEC = 300,
   parameter int unsigned SNOOZE_MAX = 3
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_tick_1hz,
   input  logic       i_btn_u,
   input  logic       i_btn_d,
   input  logic       i_btn_l,
   input  logic       i_btn_m,
   input  logic       i_btn_r,
   input  logic       i_alarm_mode,
   input  logic       i_arm,
   input  logic [3:0] i_hour_t,
   input  logic [3:0] i_hour_o,
   input  logic [3:0] i_min_t,
   input  logic [3:0] i_min_o,
   input  logic [3:0] i_sec_t,
   input  logic [3:0] i_sec_o,
   output logic [3:0] o_al_hour_t,
   output logic [3:0] o_al_hour_o,
   output logic [3:0] o_al_min_t,
   output logic [3:0] o_al_min_o,
   output logic [7:0] o_config_digit,
   output logic       o_show_alarm,
   output logic       o_ringing,
   output logic       o_snoozing
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EDIT   = 2'd1,
      ST_RING   = 2'd2,
      ST_SNOOZE = 2'd3
   } state_t;

   localparam logic [9:0] RING_LIM   = 10'(RING_SEC);
   localparam logic [9:0] SNOOZE_LIM = 10'(SNOOZE_SEC);
   localparam logic [2:0] SNZ_LIM    = 3'(SNOOZE_MAX);
   localparam logic [9:0] CNT_MAX    = 10'd1023;

   state_t      state_q, state_d;
   logic [3:0]  ht_q, ht_d, ho_q, ho_d, mt_q, mt_d, mo_q, mo_d;
   logic [1:0]  cursor_q, cursor_d;
   logic [9:0]  cnt_q, cnt_d;
   logic [2:0]  snz_q, snz_d;
   logic        match_dly_q;
   logic        match_s, trigger_s;
   logic [9:0]  cnt_inc_s;
   logic [3:0]  ho_lim_s;
   logic [7:0]  config_q;
   logic        show_q, ringing_q, snoozing_q;

   // Step a BCD digit up or down, wrapping inside 0..max_v.
   function automatic logic [3:0] wrap_step(input logic [3:0] v,
                                            input logic [3:0] max_v,
                                            input logic       up);
      logic [3:0] r;
      if (up) begin
         r = (v >= max_v) ? 4'd0 : v + 4'd1;
      end else begin
         r = (v == 4'd0) ? max_v : v - 4'd1;
      end
      return r;
   endfunction

   // Time/alarm comparison, rising-edge trigger and saturating counter increment.
   always_comb begin
      match_s   = (i_hour_t == ht_q) && (i_hour_o == ho_q) &&
                  (i_min_t == mt_q) && (i_min_o == mo_q) &&
                  (i_sec_t == 4'd0) && (i_sec_o == 4'd0);
      trigger_s = i_arm && match_s && !match_dly_q;
      cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 10'd1;
      ho_lim_s  = (ht_q == 4'd2) ? 4'd3 : 4'd9;
   end

   // Next-state logic for the mode FSM, alarm digits, cursor and counters.
   always_comb begin
      state_d  = state_q;
      ht_d     = ht_q;
      ho_d     = ho_q;
      mt_d     = mt_q;
      mo_d     = mo_q;
      cursor_d = cursor_q;
      cnt_d    = cnt_q;
      snz_d    = snz_q;
      case (state_q)
         ST_IDLE: begin
            if (i_alarm_mode) begin
               state_d  = ST_EDIT;
               cursor_d = 2'd0;
            end else if (trigger_s) begin
               state_d = ST_RING;
               cnt_d   = 10'd0;
               snz_d   = 3'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EDIT: begin
            if (i_btn_m || !i_alarm_mode) begin
               state_d = ST_IDLE;
            end else if (i_btn_u || i_btn_d) begin
               // u outranks d: the step direction follows u.
               case (cursor_q)
                  2'd0: begin
                     ht_d = wrap_step(ht_q, 4'd2, i_btn_u);
                     // Entering the 20s clamps the ones digit to keep the hour valid.
                     if ((ht_d == 4'd2) && (ho_q > 4'd3)) begin
                        ho_d = 4'd3;
                     end else begin
                        ho_d = ho_q;
                     end
                  end
                  2'd1:    ho_d = wrap_step(ho_q, ho_lim_s, i_btn_u);
                  2'd2:    mt_d = wrap_step(mt_q, 4'd5, i_btn_u);
                  2'd3:    mo_d = wrap_step(mo_q, 4'd9, i_btn_u);
                  default: mo_d = mo_q;
               endcase
            end else if (i_btn_l) begin
               cursor_d = cursor_q - 2'd1;
            end else if (i_btn_r) begin
               cursor_d = cursor_q + 2'd1;
            end else begin
               state_d = ST_EDIT;
            end
         end
         ST_RING: begin
            if (!i_arm || i_btn_m) begin
               state_d = ST_IDLE;
            end else if (i_btn_u || i_btn_d) begin
               if (snz_q < SNZ_LIM) begin
                  state_d = ST_SNOOZE;
                  snz_d   = snz_q + 3'd1;
                  cnt_d   = 10'd0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (i_tick_1hz) begin
               cnt_d = cnt_inc_s;
               if (cnt_inc_s >= RING_LIM) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_RING;
               end
            end else begin
               state_d = ST_RING;
            end
         end
         ST_SNOOZE: begin
            if (!i_arm || i_btn_m) begin
               state_d = ST_IDLE;
            end else if (i_tick_1hz) begin
               if (cnt_inc_s >= SNOOZE_LIM) begin
                  state_d = ST_RING;
                  cnt_d   = 10'd0;
               end else begin
                  cnt_d   = cnt_inc_s;
               end
            end else begin
               state_d = ST_SNOOZE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, alarm value, counters, match history and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         ht_q        <= 4'd0;
         ho_q        <= 4'd7;
         mt_q        <= 4'd0;
         mo_q        <= 4'd0;
         cursor_q    <= 2'd0;
         cnt_q       <= 10'd0;
         snz_q       <= 3'd0;
         match_dly_q <= 1'b0;
         config_q    <= 8'h00;
         show_q      <= 1'b0;
         ringing_q   <= 1'b0;
         snoozing_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ht_q        <= ht_d;
         ho_q        <= ho_d;
         mt_q        <= mt_d;
         mo_q        <= mo_d;
         cursor_q    <= cursor_d;
         cnt_q       <= cnt_d;
         snz_q       <= snz_d;
         match_dly_q <= match_s;
         config_q    <= (state_d == ST_EDIT) ? (8'h80 >> cursor_d) : 8'h00;
         show_q      <= (state_d == ST_EDIT);
         ringing_q   <= (state_d == ST_RING);
         snoozing_q  <= (state_d == ST_SNOOZE);
      end
   end

   assign o_al_hour_t    = ht_q;
   assign o_al_hour_o    = ho_q;
   assign o_al_min_t     = mt_q;
   assign o_al_min_o     = mo_q;
   assign o_config_digit = config_q;
   assign o_show_alarm   = show_q;
   assign o_ringing      = ringing_q;
   assign o_snoozing     = snoozing_q;

endmodule

// File: tb/tb_alarm_controller.sv
// ---------------------------------------------------------------------------
// tb_alarm_controller
// Directed bench for alarm_controller with a behavioural model that keeps the
// alarm as integer hour/minute and applies the editing, ringing and snooze
// rules arithmetically. Outputs are compared to the model on every falling
// edge, plus literal spot checks after key events.
// ---------------------------------------------------------------------------
module tb_alarm_controller;

   localparam int RSEC = 3;
   localparam int SSEC = 2;
   localparam int SMAX = 1;

   localparam int M_IDLE = 0, M_EDIT = 1, M_RING = 2, M_SNOOZE = 3;

   logic       clk, rst_n, tick, bu, bd, bl, bm, br, amode, arm;
   logic [3:0] hour_t, hour_o, min_t, min_o, sec_t, sec_o;
   logic [3:0] al_ht, al_ho, al_mt, al_mo;
   logic [7:0] cfg;
   logic       show, ringing, snoozing;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Model state
   int t_h, t_m, t_s;
   int mode, a_h, a_m, cur, cnt, snz;
   bit mprev;

   alarm_controller #(.RING_SEC(RSEC), .SNOOZE_SEC(SSEC), .SNOOZE_MAX(SMAX)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_tick_1hz(tick),
      .i_btn_u(bu), .i_btn_d(bd), .i_btn_l(bl), .i_btn_m(bm), .i_btn_r(br),
      .i_alarm_mode(amode), .i_arm(arm),
      .i_hour_t(hour_t), .i_hour_o(hour_o), .i_min_t(min_t), .i_min_o(min_o),
      .i_sec_t(sec_t), .i_sec_o(sec_o),
      .o_al_hour_t(al_ht), .o_al_hour_o(al_ho), .o_al_min_t(al_mt), .o_al_min_o(al_mo),
      .o_config_digit(cfg), .o_show_alarm(show), .o_ringing(ringing), .o_snoozing(snoozing)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mode = M_IDLE; a_h = 7; a_m = 0; cur = 0; cnt = 0; snz = 0; mprev = 1'b0;
   endtask

   // Step one edited digit of the alarm up (+1) or down (-1).
   task automatic bump(input int dir);
      int tens, ones, lim;
      case (cur)
         0: begin
            tens = (a_h / 10 + dir + 3) % 3;
            ones = a_h % 10;
            if (tens == 2 && ones > 3) ones = 3;
            a_h = tens * 10 + ones;
         end
         1: begin
            lim = (a_h / 10 == 2) ? 4 : 10;
            a_h = (a_h / 10) * 10 + (a_h % 10 + dir + lim) % lim;
         end
         2: a_m = ((a_m / 10 + dir + 6) % 6) * 10 + a_m % 10;
         default: a_m = (a_m / 10) * 10 + (a_m % 10 + dir + 10) % 10;
      endcase
   endtask

   task automatic model_update();
      bit match;
      match = (t_h == a_h) && (t_m == a_m) && (t_s == 0);
      case (mode)
         M_IDLE: begin
            if (amode) begin mode = M_EDIT; cur = 0; end
            else if (arm && match && !mprev) begin mode = M_RING; cnt = 0; snz = 0; end
         end
         M_EDIT: begin
            if (bm || !amode) mode = M_IDLE;
            else if (bu) bump(1);
            else if (bd) bump(-1);
            else if (bl) cur = (cur + 3) % 4;
            else if (br) cur = (cur + 1) % 4;
         end
         M_RING: begin
            if (!arm || bm) mode = M_IDLE;
            else if (bu || bd) begin
               if (snz < SMAX) begin mode = M_SNOOZE; snz++; cnt = 0; end
               else mode = M_IDLE;
            end else if (tick) begin
               cnt = (cnt + 1 > 1023) ? 1023 : cnt + 1;
               if (cnt >= RSEC) mode = M_IDLE;
            end
         end
         default: begin
            if (!arm || bm) mode = M_IDLE;
            else if (tick) begin
               cnt = cnt + 1;
               if (cnt >= SSEC) begin mode = M_RING; cnt = 0; end
            end
         end
      endcase
      mprev = match;
   endtask

   task automatic set_time(input int h, input int m, input int s);
      t_h = h; t_m = m; t_s = s;
      hour_t = 4'(h / 10); hour_o = 4'(h % 10);
      min_t  = 4'(m / 10); min_o  = 4'(m % 10);
      sec_t  = 4'(s / 10); sec_o  = 4'(s % 10);
   endtask

   // One clock: model follows the edge, then pulse inputs are cleared.
   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      tick = 1'b0; bu = 1'b0; bd = 1'b0; bl = 1'b0; bm = 1'b0; br = 1'b0;
   endtask

   task automatic trigger();
      set_time(6, 29, 59); step();
      set_time(6, 30, 0);  step();
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         chk("al_hour_t", 32'(al_ht), 32'(a_h / 10));
         chk("al_hour_o", 32'(al_ho), 32'(a_h % 10));
         chk("al_min_t",  32'(al_mt), 32'(a_m / 10));
         chk("al_min_o",  32'(al_mo), 32'(a_m % 10));
         chk("config",    32'(cfg),   (mode == M_EDIT) ? 32'(1 << (7 - cur)) : 32'd0);
         chk("show",      32'(show),  32'(mode == M_EDIT));
         chk("ringing",   32'(ringing),  32'(mode == M_RING));
         chk("snoozing",  32'(snoozing), 32'(mode == M_SNOOZE));
      end
   end

   initial begin
      rst_n = 1'b0; tick = 1'b0; bu = 1'b0; bd = 1'b0; bl = 1'b0; bm = 1'b0; br = 1'b0;
      amode = 1'b0; arm = 1'b0;
      set_time(12, 0, 0);
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;
      step();
      // Reset state
      chk("rst_hour_t", 32'(al_ht), 32'd0);
      chk("rst_hour_o", 32'(al_ho), 32'd7);
      chk("rst_min_o",  32'(al_mo), 32'd0);
      chk("rst_cfg",    32'(cfg),   32'd0);
      chk("rst_ring",   32'(ringing), 32'd0);

      // Editing: 07:00 -> u,u -> 23:00
      amode = 1'b1; step();
      chk("edit_cfg0", 32'(cfg), 32'h80);
      chk("edit_show", 32'(show), 32'd1);
      bu = 1'b1; step();
      bu = 1'b1; step();
      chk("clamp_ht", 32'(al_ht), 32'd2);
      chk("clamp_ho", 32'(al_ho), 32'd3);
      bl = 1'b1; step();
      chk("cursor3_cfg", 32'(cfg), 32'h10);
      bd = 1'b1; step();
      chk("min_o_wrap", 32'(al_mo), 32'd9);
      // m and u together: exit only
      bm = 1'b1; bu = 1'b1; amode = 1'b0; step();
      chk("mu_exit_show", 32'(show), 32'd0);
      chk("mu_min_o",     32'(al_mo), 32'd9);
      chk("mu_cfg",       32'(cfg), 32'd0);

      // Edit 23:09 -> 06:30
      amode = 1'b1; step();
      bd = 1'b1; step();
      bd = 1'b1; step();
      br = 1'b1; step();
      repeat (3) begin bu = 1'b1; step(); end
      br = 1'b1; step();
      repeat (3) begin bu = 1'b1; step(); end
      br = 1'b1; step();
      bu = 1'b1; step();
      amode = 1'b0; step();
      chk("set_ht", 32'(al_ht), 32'd0);
      chk("set_ho", 32'(al_ho), 32'd6);
      chk("set_mt", 32'(al_mt), 32'd3);
      chk("set_mo", 32'(al_mo), 32'd0);

      // Disarmed: never rings
      arm = 1'b0; trigger(); step(); step();
      chk("disarmed_ring", 32'(ringing), 32'd0);

      // Armed: rings one cycle after 06:30:00, stop, no retrigger
      arm = 1'b1; trigger();
      chk("trig_ring", 32'(ringing), 32'd1);
      step();
      bm = 1'b1; step();
      chk("stop_ring", 32'(ringing), 32'd0);
      repeat (3) step();
      chk("no_retrig", 32'(ringing), 32'd0);

      // Auto-stop after RSEC ticks
      trigger();
      tick = 1'b1; step(); step();
      tick = 1'b1; step();
      chk("ring_2ticks", 32'(ringing), 32'd1);
      tick = 1'b1; step();
      chk("ring_3ticks", 32'(ringing), 32'd0);

      // Snooze, re-ring, second snooze request stops
      trigger();
      bu = 1'b1; step();
      chk("snz_on",   32'(snoozing), 32'd1);
      chk("snz_ring", 32'(ringing), 32'd0);
      tick = 1'b1; step(); step();
      chk("snz_1tick", 32'(snoozing), 32'd1);
      tick = 1'b1; step();
      chk("rering", 32'(ringing), 32'd1);
      bu = 1'b1; step();
      chk("snzmax_ring", 32'(ringing), 32'd0);
      chk("snzmax_snz",  32'(snoozing), 32'd0);

      // Disarm together with u in RING
      trigger();
      arm = 1'b0; bu = 1'b1; step();
      chk("disarm_u_ring", 32'(ringing), 32'd0);
      chk("disarm_u_snz",  32'(snoozing), 32'd0);
      arm = 1'b1; step();

      // Asynchronous reset in the middle of RING
      trigger();
      chk("pre_rst_ring", 32'(ringing), 32'd1);
      #3 rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_async_ring", 32'(ringing), 32'd0);
      chk("rst_async_ho",   32'(al_ho), 32'd7);
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      chk("post_rst_ring", 32'(ringing), 32'd0);
      chk("post_rst_mt",   32'(al_mt), 32'd0);
      repeat (3) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
